// File: rtl/block_memory_pkg.sv
// Shared definitions for the block memory and the cache controller that sits in front of it.
// Holds the access FSM state encoding and the default geometry and timing constants.
package block_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W          = 32;
    localparam int DEF_ADDR_W          = 15;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_LATENCY         = 4;

endpackage

// File: rtl/block_memory_mem_array.sv
// Block-wide storage: one synchronous port that reads or writes a whole aligned block per access.
// Output registers clear on reset; the storage itself is never touched by reset.
module mem_array #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 15,
    parameter int WORDS_PER_BLOCK = 4,
    localparam int OFF_W          = $clog2(WORDS_PER_BLOCK),
    localparam int BASE_W         = ADDR_W - OFF_W,
    localparam int BLK_W          = DATA_W * WORDS_PER_BLOCK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [BASE_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    input  logic [BLK_W-1:0]  wblock,
    output logic [BLK_W-1:0]  rblock,
    output logic [DATA_W-1:0] rword
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Words are stored XORed with their own address, so the zero power-up
    // state of a 2-state array reads back as the preload pattern word i = i.
    bit [DATA_W-1:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] word_adr(input logic [BASE_W-1:0] b, input int k);
        return {b, OFF_W'(k)};
    endfunction

    function automatic logic [DATA_W-1:0] fill(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                mem[word_adr(base, k)] <= wblock[k*DATA_W +: DATA_W] ^ fill(word_adr(base, k));
            end
        end
    end

    // A write returns its own data, so no read-during-write ordering is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rblock <= '0;
            rword  <= '0;
        end else if (en) begin
            if (we) begin
                rblock <= wblock;
                rword  <= wblock[int'(offset)*DATA_W +: DATA_W];
            end else begin
                for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                    rblock[k*DATA_W +: DATA_W] <= mem[word_adr(base, k)] ^ fill(word_adr(base, k));
                end
                rword <= mem[{base, offset}] ^ fill({base, offset});
            end
        end
    end

endmodule

// File: rtl/block_memory.sv
// Fixed-latency block memory: latches one request in IDLE, waits LATENCY cycles, performs
// a whole-block read or write, then holds the result with ready high until acknowledged.
module block_memory
    import block_memory_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int LATENCY         = DEF_LATENCY,
    localparam int BLK_W          = DATA_W * WORDS_PER_BLOCK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [BLK_W-1:0]  wblock,
    input  logic              ack,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] rword,
    output logic [BLK_W-1:0]  rblock
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               access;
    logic [ADDR_W-1:0]  adr_q;
    logic               we_q;
    logic [BLK_W-1:0]   wblock_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request fields are captured only on acceptance, isolating the access in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            adr_q    <= Adr;
            we_q     <= we;
            wblock_q <= wblock;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == WAIT) || (state == DONE);
    assign ready = (state == DONE);

    mem_array #(
        .DATA_W          (DATA_W),
        .ADDR_W          (ADDR_W),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (access),
        .we     (we_q),
        .base   (adr_q[ADDR_W-1:OFF_W]),
        .offset (adr_q[OFF_W-1:0]),
        .wblock (wblock_q),
        .rblock (rblock),
        .rword  (rword)
    );

endmodule

// File: tb/tb_block_memory.sv
// Directed bench for block_memory (32-bit words, 4-word blocks, latency 3): a vector
// table of reads and writes plus hand sequences for ignored start, ack+start and resets.
module tb_block_memory;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         we;
    logic [14:0]  Adr;
    logic [127:0] wblock;
    logic         ack;
    logic         busy;
    logic         ready;
    logic [31:0]  rword;
    logic [127:0] rblock;

    int tests  = 0;
    int failed = 0;

    block_memory #(
        .DATA_W          (32),
        .ADDR_W          (15),
        .WORDS_PER_BLOCK (4),
        .LATENCY         (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .we     (we),
        .Adr    (Adr),
        .wblock (wblock),
        .ack    (ack),
        .busy   (busy),
        .ready  (ready),
        .rword  (rword),
        .rblock (rblock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         w;
        logic [14:0]  a;
        logic [127:0] wb;
        logic [127:0] exp_rb;
        logic [31:0]  exp_rw;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for ready; checks busy and the exact latency.
    task automatic run_txn(input logic w, input logic [14:0] a, input logic [127:0] wb,
                           input bit hold_start, input string tag);
        int n;
        @(negedge clk);
        start  = 1'b1;
        we     = w;
        Adr    = a;
        wblock = wb;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        we     = ~w;
        Adr    = ~a;
        wblock = ~wb;
        check({tag, "_busy_wait"}, 128'(busy), 128'(1));
        check({tag, "_ready_wait"}, 128'(ready), 128'(0));
        n = 0;
        while (!ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(3));
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check({tag, "_ready_after_ack"}, 128'(ready), 128'(0));
        check({tag, "_busy_after_ack"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0] = '{1'b0, 15'h0006, 128'h0, 128'h00000007_00000006_00000005_00000004, 32'h6};
        vecs[1] = '{1'b1, 15'h0011, 128'h0000000D_0000000C_0000000B_0000000A,
                    128'h0000000D_0000000C_0000000B_0000000A, 32'hB};
        vecs[2] = '{1'b0, 15'h0013, 128'h0, 128'h0000000D_0000000C_0000000B_0000000A, 32'hD};
        vecs[3] = '{1'b0, 15'h000F, 128'h0, 128'h0000000F_0000000E_0000000D_0000000C, 32'hF};
        vecs[4] = '{1'b1, 15'h0102, 128'h11111111_22222222_33333333_44444444,
                    128'h11111111_22222222_33333333_44444444, 32'h22222222};
        vecs[5] = '{1'b0, 15'h0103, 128'h0, 128'h11111111_22222222_33333333_44444444, 32'h11111111};
        vecs[6] = '{1'b0, 15'h0014, 128'h0, 128'h00000017_00000016_00000015_00000014, 32'h14};

        rst_n  = 1'b0;
        start  = 1'b0;
        we     = 1'b0;
        Adr    = '0;
        wblock = '0;
        ack    = 1'b0;
        #3;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_ready", 128'(ready), 128'(0));
        check("reset_rword", 128'(rword), 128'(0));
        check("reset_rblock", rblock, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ack while idle must not do anything.
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("idle_ack_busy", 128'(busy), 128'(0));

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_txn(vecs[i].w, vecs[i].a, vecs[i].wb, 1'b0, tag);
            check({tag, "_rblock"}, rblock, vecs[i].exp_rb);
            check({tag, "_rword"}, 128'(rword), 128'(vecs[i].exp_rw));
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_ready_hold"}, 128'(ready), 128'(1));
            check({tag, "_rblock_hold"}, rblock, vecs[i].exp_rb);
            do_ack(tag);
        end

        // Top-of-memory block with start held high through WAIT and DONE.
        run_txn(1'b0, 15'h7FFF, 128'h0, 1'b1, "top");
        check("top_rblock", rblock, 128'h00007FFF_00007FFE_00007FFD_00007FFC);
        check("top_rword", 128'(rword), 128'(32'h7FFF));
        repeat (3) @(posedge clk);
        #1;
        check("top_busy_hold", 128'(busy), 128'(1));
        check("top_ready_hold", 128'(ready), 128'(1));
        check("top_rblock_hold", rblock, 128'h00007FFF_00007FFE_00007FFD_00007FFC);
        do_ack("top");
        repeat (3) @(posedge clk);
        #1;
        check("top_no_second_access", 128'(busy), 128'(0));

        // ack and start together in DONE: back to IDLE, start dropped.
        run_txn(1'b0, 15'h000F, 128'h0, 1'b0, "ackstart");
        @(negedge clk);
        ack   = 1'b1;
        start = 1'b1;
        we    = 1'b0;
        Adr   = 15'h0006;
        @(posedge clk); #1;
        ack   = 1'b0;
        start = 1'b0;
        check("ackstart_ready", 128'(ready), 128'(0));
        check("ackstart_busy", 128'(busy), 128'(0));
        repeat (4) @(posedge clk);
        #1;
        check("ackstart_still_idle", 128'(busy), 128'(0));
        check("ackstart_rblock_kept", rblock, 128'h0000000F_0000000E_0000000D_0000000C);

        // Asynchronous reset while holding a result in DONE.
        run_txn(1'b0, 15'h0006, 128'h0, 1'b0, "rstdone");
        #3;
        rst_n = 1'b0;
        #1;
        check("rstdone_ready", 128'(ready), 128'(0));
        check("rstdone_busy", 128'(busy), 128'(0));
        check("rstdone_rblock", rblock, 128'(0));
        check("rstdone_rword", 128'(rword), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset during WAIT discards the pending write.
        @(negedge clk);
        start  = 1'b1;
        we     = 1'b1;
        Adr    = 15'h0020;
        wblock = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        check("abort_ready_never", 128'(seen), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(1'b0, 15'h0020, 128'h0, 1'b0, "abort_read");
        check("abort_read_rblock", rblock, 128'h00000023_00000022_00000021_00000020);
        check("abort_read_rword", 128'(rword), 128'(32'h20));
        do_ack("abort_read");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/block_memory.md
BLOCK_MEMORY -- requirements
Module: block_memory

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 15, word-address width; depth = 2**ADDR_W words.
REQ-003 Parameter WORDS_PER_BLOCK, default 4, power of two, at least 2; the block (line) size in words.
REQ-004 Parameter LATENCY, default 4, at least 1; cycles from the accepted start to ready.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  request strobe; sampled only in IDLE.
REQ-008 we  input  1  1 = block write, 0 = block read; sampled with start.
REQ-009 Adr  input  ADDR_W  word address; sampled with start.
REQ-010 wblock  input  DATA_W*WORDS_PER_BLOCK  write data; word k sits at bits [k*DATA_W +: DATA_W]; sampled with start.
REQ-011 ack  input  1  consumer acknowledge; releases ready.
REQ-012 busy  output  1  high in WAIT and DONE.
REQ-013 ready  output  1  high in DONE only.
REQ-014 rword  output  DATA_W  the word at the latched Adr (critical word).
REQ-015 rblock  output  DATA_W*WORDS_PER_BLOCK  the aligned block; same packing as wblock.

Function
REQ-016 The FSM has three states: IDLE, WAIT and DONE.
REQ-017 In IDLE, when start=1, the block latches Adr, we and wblock, loads the counter with LATENCY-1 and moves to WAIT.
REQ-018 Base address = Adr with its low log2(WORDS_PER_BLOCK) bits cleared; a block never crosses the top of memory.
REQ-019 In WAIT, the counter decrements each cycle; at 0 the block performs the access and moves to DONE, so ready rises exactly LATENCY cycles after the start edge.
REQ-020 Read: rblock word k = mem[base+k]; rword = mem[latched Adr]; both are registered on the WAIT-to-DONE edge.
REQ-021 Write: mem[base+k] = wblock word k for all k, committed on the WAIT-to-DONE edge; rblock returns the written data; rword returns the written word at the latched Adr.
REQ-022 In DONE, ready and the outputs hold until ack=1, which moves the FSM to IDLE on that edge.
REQ-023 start in WAIT or DONE is ignored, and no request is queued.
REQ-024 ack=1 and start=1 in the same DONE cycle: the FSM goes to IDLE and start is ignored; a new request needs start in IDLE.
REQ-025 ack outside DONE is ignored.
REQ-026 Changes to Adr, we or wblock after acceptance do not affect the access in flight.
REQ-027 A read of a block written earlier returns the new data, with no stale-read window.
REQ-028 Memory word i = i (truncated to DATA_W) at time zero; this is a simulation preload.

Reset
REQ-029 rst_n=0 forces IDLE asynchronously: busy=0, ready=0, rword=0, rblock=0, counter=0.
REQ-030 Reset never alters memory contents.
REQ-031 Reset during WAIT aborts the access; an uncommitted write is discarded.
REQ-032 After rst_n is released, the first start is honoured on the first rising edge.

Structure
REQ-033 A shared package holds the state enum (IDLE, WAIT, DONE) and the default parameter constants; the cache controller reuses both.
REQ-034 The storage array is one sub-module, mem_array: a synchronous port that reads or writes a whole block, with the preload.
REQ-035 The FSM, counter and latch registers live in block_memory.

Verification (DATA_W=32, ADDR_W=15, WORDS_PER_BLOCK=4, LATENCY=3)
REQ-036 Reset, then start, we=0, Adr=0x0006 -> ready=1 exactly 3 cycles later; rblock words 0..3 = 4,5,6,7; rword=6; holds until ack.
REQ-037 Write Adr=0x0011, wblock={0xA,0xB,0xC,0xD} (words 0..3), ack, then read Adr=0x0013 -> rblock={0xA,0xB,0xC,0xD}, rword=0xD.
REQ-038 Read Adr=0x7FFF -> rblock=0x7FFC..0x7FFF, rword=0x7FFF; start pulsed during WAIT and DONE -> no second access, busy stays 1 until ack.
REQ-039 Write to 0x0020 with rst_n=0 one cycle after start -> ready never rises; a later read of 0x0020 returns 0x20..0x23.
REQ-040 In DONE, ack=1 and start=1 together -> IDLE next cycle, ready=0, busy=0, no new access.
